// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - memory request/ready handshake between controller and memory
interface multicycle_ctrl_if;
    logic MemReq;
    logic MemWrite;
    logic AdrSrc;
    logic mem_ready;

    modport master (
        output MemReq,
        output MemWrite,
        output AdrSrc,
        input  mem_ready
    );

    modport slave (
        input  MemReq,
        input  MemWrite,
        input  AdrSrc,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RISC-V style control FSM with memory wait timeout and sticky fault
module multicycle_ctrl #(
    parameter int ALUCTRL_W = 4,
    parameter int MAX_WAIT  = 15,
    parameter bit JALR_EN   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  zero,
    multicycle_ctrl_if.master     mem,
    output logic                  PCWrite,
    output logic                  IRWrite,
    output logic [1:0]            ResultSrc,
    output logic [ALUCTRL_W-1:0]  ALUControl,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [2:0]            ImmSrc,
    output logic                  RegWrite,
    output logic                  instr_done,
    output logic                  Fault
);

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI,
        S_AUIPC, S_FAULT
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;
    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b100;

    // A zero-width counter is illegal, so MAX_WAIT=0 keeps one unused bit.
    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_req;
    logic             mem_write;
    logic             adr_src;
    logic [3:0]       alu_op;
    logic             timeout;
    logic             enter_wait_state;

    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7, input logic rtype);
        logic [3:0] r;
        case (f3)
            3'b000:  r = (rtype && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = f7 ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    assign timeout = (MAX_WAIT > 0) && mem_req && !mem.mem_ready && (wait_cnt == WAIT_LIM);
    assign enter_wait_state = (state_nxt != state) &&
                              (state_nxt == S_FETCH || state_nxt == S_MEMREAD || state_nxt == S_MEMWRITE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET:  state_nxt = S_FETCH;
            S_FETCH: begin
                if (mem.mem_ready)  state_nxt = S_DECODE;
                else if (timeout)   state_nxt = S_FAULT;
            end
            S_DECODE: begin
                case (op)
                    7'b0000011, 7'b0100011: state_nxt = S_MEMADR;
                    7'b0110011: state_nxt = S_EXECUTER;
                    7'b0010011: state_nxt = S_EXECUTEI;
                    // funct3 010/011 are not defined branch conditions
                    7'b1100011: state_nxt = (funct3[2:1] == 2'b01) ? S_FAULT : S_BRANCH;
                    7'b1101111: state_nxt = S_JAL;
                    7'b1100111: state_nxt = (JALR_EN && funct3 == 3'b000) ? S_JALR : S_FAULT;
                    7'b0110111: state_nxt = S_LUI;
                    7'b0010111: state_nxt = S_AUIPC;
                    default:    state_nxt = S_FAULT;
                endcase
            end
            S_MEMADR: state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem.mem_ready)  state_nxt = S_MEMWB;
                else if (timeout)   state_nxt = S_FAULT;
            end
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWRITE: begin
                if (mem.mem_ready)  state_nxt = S_FETCH;
                else if (timeout)   state_nxt = S_FAULT;
            end
            S_EXECUTER, S_EXECUTEI, S_JAL, S_LUI, S_AUIPC: state_nxt = S_ALUWB;
            S_ALUWB:  state_nxt = S_FETCH;
            S_BRANCH: state_nxt = S_FETCH;
            S_JALR:   state_nxt = S_JAL;
            default:  state_nxt = S_FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_RESET;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (enter_wait_state)
                wait_cnt <= '0;
            else if (mem_req && !mem.mem_ready)
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Outputs decode from state (plus same-cycle mem_ready/zero), so reset zeroes them at once.
    always_comb begin
        PCWrite    = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        mem_req    = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = RES_ALUOUT;
        alu_op     = ALU_ADD;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        ImmSrc     = IMM_I;
        RegWrite   = 1'b0;
        instr_done = 1'b0;
        Fault      = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem.mem_ready) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = op[5] ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req    = 1'b1;
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem.mem_ready;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                alu_op  = alu_decode(funct3, funct7_5, 1'b1);
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_I;
                alu_op  = alu_decode(funct3, funct7_5, 1'b0);
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_RD2;
                instr_done = 1'b1;
                case (funct3[2:1])
                    2'b10:   alu_op = ALU_SLT;
                    2'b11:   alu_op = ALU_SLTU;
                    default: alu_op = ALU_SUB;
                endcase
                // beq/bge/bgeu take on zero, bne/blt/bltu on !zero
                PCWrite = zero ^ (funct3[0] ^ funct3[2]);
            end
            S_JALR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_I;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            S_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_U;
            end
            S_AUIPC: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_U;
            end
            S_FAULT: Fault = 1'b1;
            default: ;
        endcase
    end

    assign ALUControl   = ALUCTRL_W'(alu_op);
    assign mem.MemReq   = mem_req;
    assign mem.MemWrite = mem_write;
    assign mem.AdrSrc   = adr_src;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter ALUCTRL_W, default 4: ALUControl width (>=4, upper bits zero).
REQ-002 SHALL have parameter MAX_WAIT, default 15: memory wait-cycle limit before fault (0 disables timeout).
REQ-003 SHALL have parameter JALR_EN, default 1: 1 enables JALR decode, 0 treats JALR as illegal.
REQ-004 SHALL have port clk  in  1  single clock, rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port op  in  7  instruction opcode.
REQ-007 SHALL have port funct3  in  3  instruction funct3.
REQ-008 SHALL have port funct7_5  in  1  instruction bit 30.
REQ-009 SHALL have port zero  in  1  ALU result-zero flag.
REQ-010 SHALL have port mem_ready  in  1  memory completes the current request.
REQ-011 SHALL have port PCWrite  out  1  PC load enable.
REQ-012 SHALL have port AdrSrc  out  1  memory address select (0 PC, 1 ALUOut).
REQ-013 SHALL have port MemWrite  out  1  memory write strobe.
REQ-014 SHALL have port MemReq  out  1  memory request valid.
REQ-015 SHALL have port IRWrite  out  1  instruction/OldPC register load.
REQ-016 SHALL have port ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
REQ-017 SHALL have port ALUControl  out  ALUCTRL_W  ADD0 SUB1 AND2 OR3 XOR4 SLT5 SLTU6 SLL7 SRL8 SRA9.
REQ-018 SHALL have port ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1, 11 constant zero.
REQ-019 SHALL have port ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4.
REQ-020 SHALL have port ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
REQ-021 SHALL have port RegWrite  out  1  register-file write enable.
REQ-022 SHALL have port instr_done  out  1  one-cycle pulse in each instruction's final cycle.
REQ-023 SHALL have port Fault  out  1  sticky illegal-instruction/memory-timeout flag.

Function
REQ-024 SHALL be a Moore/Mealy FSM, states RESET FETCH DECODE MEMADR MEMREAD MEMWB MEMWRITE EXECUTER EXECUTEI ALUWB BRANCH JAL JALR LUI AUIPC FAULT; every output not listed for a state drives 0.
REQ-025 RESET -> FETCH unconditionally next cycle.
REQ-026 FETCH: MemReq=1, AdrSrc=0; when mem_ready=1 same cycle IRWrite=1, PCWrite=1, SrcA=00, SrcB=10, ADD, ResultSrc=10, -> DECODE; else stay.
REQ-027 DECODE: SrcA=01, SrcB=01, ImmSrc=010, ADD; op 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1100011->BRANCH (funct3 010/011 ->FAULT), 1101111->JAL, 1100111 with funct3=000 and JALR_EN->JALR, 0110111->LUI, 0010111->AUIPC, else FAULT.
REQ-028 MEMADR: SrcA=10, SrcB=01, ADD, ImmSrc I if op[5]=0 else S; op[5]=0->MEMREAD else MEMWRITE.
REQ-029 MEMREAD: MemReq=1, AdrSrc=1; mem_ready->MEMWB. MEMWB: ResultSrc=01, RegWrite=1, instr_done=1 ->FETCH.
REQ-030 MEMWRITE: MemReq=1, AdrSrc=1, MemWrite=1; mem_ready -> FETCH with instr_done=1.
REQ-031 EXECUTER: SrcA=10, SrcB=00; EXECUTEI: SrcA=10, SrcB=01, ImmSrc I; both ->ALUWB.
REQ-032 ALU decode by funct3: 000 ADD (SUB only if R-type and funct7_5), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by funct7_5, 110 OR, 111 AND.
REQ-033 ALUWB: ResultSrc=00, RegWrite=1, instr_done=1 -> FETCH.
REQ-034 BRANCH: SrcA=10, SrcB=00, ResultSrc=00, instr_done=1; beq/bne SUB, blt/bge SLT, bltu/bgeu SLTU; PCWrite = zero for beq/bge/bgeu, !zero for bne/blt/bltu -> FETCH.
REQ-035 JALR: SrcA=10, SrcB=01, ImmSrc I, ADD -> JAL. JAL: SrcA=01, SrcB=10, ADD, ResultSrc=00, PCWrite=1 -> ALUWB.
REQ-036 LUI: SrcA=11, SrcB=01, ImmSrc U, ADD; AUIPC: SrcA=01, same otherwise; both ->ALUWB.
REQ-037 Wait counter ($clog2(MAX_WAIT+1) bits) SHALL clear on entering FETCH/MEMREAD/MEMWRITE, increment each cycle MemReq=1 and mem_ready=0; counter==MAX_WAIT with mem_ready=0 (MAX_WAIT>0) -> FAULT.
REQ-038 FAULT: Fault=1, all enables/strobes 0, held until reset_n low.

Reset
REQ-039 reset_n low SHALL immediately force state RESET, wait counter 0, all outputs 0 (incl. Fault) irrespective of clk, including mid memory access.

Verification
REQ-040 mem_ready=1, lw: FETCH->DECODE->MEMADR->MEMREAD->MEMWB->FETCH, 5 cycles; MEMWB RegWrite=1, ResultSrc=01, instr_done=1.
REQ-041 FETCH, mem_ready low 3 cycles then high: MemReq high 4 cycles, IRWrite/PCWrite only in 4th.
REQ-042 MAX_WAIT=15, mem_ready held low in MEMREAD 16 cycles -> FAULT, Fault=1 until reset_n low.
REQ-043 beq zero=1 -> ALUControl=1, PCWrite=1; bne zero=1 -> PCWrite=0; op=0000000 -> FAULT after DECODE.
REQ-044 R-type funct3=000 funct7_5=1 -> ALUControl=1; I-type funct3=000 funct7_5=1 -> ALUControl=0.
REQ-045 reset_n low mid MEMWRITE -> MemWrite=0 same cycle, state RESET, FETCH one cycle after release.
